// File: rtl/data_cache_pkg.sv
// Shared constants, FSM state encodings, the line record and the store-merge
// helper used by the direct-mapped data cache.
package data_cache_pkg;

  localparam int LINE_BYTES = 16;
  localparam int LINE_BITS  = LINE_BYTES * 8;
  localparam int OFF_W      = $clog2(LINE_BYTES);
  localparam int TAG_W      = 32 - OFF_W;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WRITEBACK = 2'd1;
  localparam logic [1:0] ST_FILL      = 2'd2;
  localparam logic [1:0] ST_INSTALL   = 2'd3;

  // Tags are stored zero-extended to the widest possible tag so the record
  // does not depend on the line count.
  typedef struct packed {
    logic                 valid;
    logic                 dirty;
    logic [TAG_W-1:0]     tag;
    logic [LINE_BITS-1:0] data;
  } line_t;

  function automatic logic [LINE_BITS-1:0] merge_store(
    input logic [LINE_BITS-1:0] line,
    input logic [3:0]           offset,
    input logic                 byte_en,
    input logic [31:0]          wdata
  );
    logic [LINE_BITS-1:0] res;
    res = line;
    if (byte_en) begin
      res[{offset, 3'b000} +: 8] = wdata[7:0];
    end else begin
      res[{offset[3:2], 5'b00000} +: 32] = wdata;
    end
    return res;
  endfunction

endpackage

// File: rtl/data_cache_if.sv
// Requester-side and backing-memory-side bus of the data cache; the cache
// takes the slave view, its environment the master view.
interface data_cache_if;
  import data_cache_pkg::*;

  logic                 req_valid;
  logic                 req_we;
  logic                 req_byte;
  logic [31:0]          req_addr;
  logic [31:0]          req_wdata;
  logic [31:0]          rsp_rdata;
  logic                 rsp_hit;
  logic                 stall_out;
  logic                 mem_req_valid;
  logic                 mem_req_we;
  logic [31:0]          mem_req_addr;
  logic [LINE_BITS-1:0] mem_req_wdata;
  logic                 mem_rsp_valid;
  logic [LINE_BITS-1:0] mem_rsp_rdata;

  modport master (
    output req_valid, req_we, req_byte, req_addr, req_wdata,
    input  rsp_rdata, rsp_hit, stall_out,
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
    output mem_rsp_valid, mem_rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_byte, req_addr, req_wdata,
    output rsp_rdata, rsp_hit, stall_out,
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
    input  mem_rsp_valid, mem_rsp_rdata
  );

endinterface

// File: rtl/data_cache_array.sv
// Tag/data storage: combinational read port, one synchronous write port.
// Only the valid and dirty bits are reset; tag and data are don't-care.
module data_cache_array #(
  parameter int NUM_LINES = 4,
  localparam int IDX_W    = $clog2(NUM_LINES)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [IDX_W-1:0]              rd_idx,
  output data_cache_pkg::line_t         rd_line,
  input  logic                          wr_en,
  input  logic [IDX_W-1:0]              wr_idx,
  input  data_cache_pkg::line_t         wr_line
);
  import data_cache_pkg::*;

  logic [NUM_LINES-1:0] valid_r;
  logic [NUM_LINES-1:0] dirty_r;
  logic [TAG_W-1:0]     tag_r  [NUM_LINES];
  logic [LINE_BITS-1:0] data_r [NUM_LINES];

  // Status bits
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= '0;
      dirty_r <= '0;
    end else if (wr_en) begin
      valid_r[wr_idx] <= wr_line.valid;
      dirty_r[wr_idx] <= wr_line.dirty;
    end
  end

  // Tag and data payload
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_r[wr_idx]  <= wr_line.tag;
      data_r[wr_idx] <= wr_line.data;
    end
  end

  // Read port
  always_comb begin
    rd_line       = '0;
    rd_line.valid = valid_r[rd_idx];
    rd_line.dirty = dirty_r[rd_idx];
    rd_line.tag   = tag_r[rd_idx];
    rd_line.data  = data_r[rd_idx];
  end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-back, write-allocate data cache. A miss stalls the
// requester, optionally writes back the dirty victim, fills, installs and
// then replays the held request as a hit.
module data_cache #(
  parameter int NUM_LINES  = 4,
  parameter int LINE_BYTES = 16
) (
  input logic         clk,
  input logic         rst,
  data_cache_if.slave bus
);
  import data_cache_pkg::*;

  localparam int LOFF_W = $clog2(LINE_BYTES);
  localparam int IDX_W  = $clog2(NUM_LINES);

  logic [1:0]           state_r;
  logic [1:0]           state_next_s;
  logic [TAG_W-1:0]     miss_line_r;
  logic [LINE_BITS-1:0] fill_data_r;
  logic [IDX_W-1:0]     req_idx_s;
  logic [IDX_W-1:0]     miss_idx_s;
  logic [IDX_W-1:0]     rd_idx_s;
  logic [IDX_W-1:0]     wr_idx_s;
  logic [TAG_W-1:0]     req_tag_s;
  logic [TAG_W-1:0]     miss_tag_s;
  line_t                rd_line_s;
  line_t                wr_line_s;
  logic                 wr_en_s;
  logic                 hit_s;
  logic                 miss_s;
  logic [31:0]          word_s;
  logic [31:0]          wb_addr_s;

  assign req_idx_s  = bus.req_addr[LOFF_W +: IDX_W];
  assign req_tag_s  = TAG_W'(bus.req_addr >> (LOFF_W + IDX_W));
  assign miss_idx_s = miss_line_r[IDX_W-1:0];
  assign miss_tag_s = miss_line_r >> IDX_W;
  // Outside IDLE the array is addressed by the latched miss line (victim view).
  assign rd_idx_s   = (state_r == ST_IDLE) ? req_idx_s : miss_idx_s;

  assign hit_s  = (state_r == ST_IDLE) && bus.req_valid && rd_line_s.valid &&
                  (rd_line_s.tag == req_tag_s);
  assign miss_s = (state_r == ST_IDLE) && bus.req_valid && !hit_s;
  assign word_s = rd_line_s.data[{bus.req_addr[3:2], 5'b00000} +: 32];
  assign wb_addr_s = (32'(rd_line_s.tag) << (LOFF_W + IDX_W)) |
                     (32'(miss_idx_s) << LOFF_W);

  data_cache_array #(.NUM_LINES(NUM_LINES)) u_array (
    .clk     (clk),
    .rst     (rst),
    .rd_idx  (rd_idx_s),
    .rd_line (rd_line_s),
    .wr_en   (wr_en_s),
    .wr_idx  (wr_idx_s),
    .wr_line (wr_line_s)
  );

  // Requester response
  always_comb begin
    bus.rsp_hit   = hit_s;
    bus.rsp_rdata = 32'd0;
    if (!hit_s) begin
      bus.rsp_rdata = 32'd0;
    end else if (bus.req_byte) begin
      bus.rsp_rdata = {24'd0, word_s[{bus.req_addr[1:0], 3'b000} +: 8]};
    end else begin
      bus.rsp_rdata = word_s;
    end
    bus.stall_out = (state_r == ST_IDLE) ? miss_s : 1'b1;
  end

  // Array write: install of a filled line or merge of a store hit
  always_comb begin
    wr_en_s   = 1'b0;
    wr_idx_s  = req_idx_s;
    wr_line_s = rd_line_s;
    if (state_r == ST_INSTALL) begin
      wr_en_s         = 1'b1;
      wr_idx_s        = miss_idx_s;
      wr_line_s.valid = 1'b1;
      wr_line_s.dirty = 1'b0;
      wr_line_s.tag   = miss_tag_s;
      wr_line_s.data  = fill_data_r;
    end else if (hit_s && bus.req_we) begin
      wr_en_s         = 1'b1;
      wr_line_s.dirty = 1'b1;
      wr_line_s.data  = merge_store(rd_line_s.data, bus.req_addr[3:0],
                                    bus.req_byte, bus.req_wdata);
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Miss sequencing
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (miss_s) begin
          state_next_s = (rd_line_s.valid && rd_line_s.dirty) ? ST_WRITEBACK : ST_FILL;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_WRITEBACK: begin
        if (bus.mem_rsp_valid) begin
          state_next_s = ST_FILL;
        end else begin
          state_next_s = ST_WRITEBACK;
        end
      end
      ST_FILL: begin
        if (bus.mem_rsp_valid) begin
          state_next_s = ST_INSTALL;
        end else begin
          state_next_s = ST_FILL;
        end
      end
      ST_INSTALL: state_next_s = ST_IDLE;
      default:    state_next_s = ST_IDLE;
    endcase
  end

  // Backing-memory request, driven purely from state and latched address
  always_comb begin
    bus.mem_req_valid = 1'b0;
    bus.mem_req_we    = 1'b0;
    bus.mem_req_addr  = 32'd0;
    bus.mem_req_wdata = '0;
    case (state_r)
      ST_WRITEBACK: begin
        bus.mem_req_valid = 1'b1;
        bus.mem_req_we    = 1'b1;
        bus.mem_req_addr  = wb_addr_s;
        bus.mem_req_wdata = rd_line_s.data;
      end
      ST_FILL: begin
        bus.mem_req_valid = 1'b1;
        bus.mem_req_addr  = {miss_line_r, 4'b0000};
      end
      default: begin
        bus.mem_req_valid = 1'b0;
      end
    endcase
  end

  // State, miss address and fill buffer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      miss_line_r <= '0;
      fill_data_r <= '0;
    end else begin
      state_r <= state_next_s;
      if (miss_s) begin
        miss_line_r <= bus.req_addr[31:4];
      end
      if ((state_r == ST_FILL) && bus.mem_rsp_valid) begin
        fill_data_r <= bus.mem_rsp_rdata;
      end
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache: a table of accesses with hand-computed
// results plus hand-written reset sequences; the bench plays the memory.
module tb_data_cache;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  data_cache_if bus_if();

  data_cache #(.NUM_LINES(4), .LINE_BYTES(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  typedef struct {
    string        name;
    logic         we;
    logic         byt;
    logic [31:0]  addr;
    logic [31:0]  wdata;
    int           lat;
    bit           chk_rd;
    logic [31:0]  exp_rdata;
    int           exp_stalls;
    int           exp_wb;
    logic [31:0]  exp_wb_addr;
    logic [127:0] exp_wb_data;
    int           exp_fill;
    logic [31:0]  exp_fill_addr;
  } vec_t;

  int checks = 0;
  int failures = 0;
  logic [127:0] mem_img [logic [31:0]];
  vec_t vecs [18];

  int           obs_stalls, obs_wb, obs_fill;
  logic [31:0]  obs_rdata, obs_wb_addr, obs_fill_addr;
  logic [127:0] obs_wb_data;
  bit           obs_done, obs_leak;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check128(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic we, input logic byt,
                              input logic [31:0] addr, input logic [31:0] wdata, input int lat,
                              input bit chk_rd, input logic [31:0] exp_rdata, input int exp_stalls,
                              input int exp_wb, input logic [31:0] exp_wb_addr,
                              input logic [127:0] exp_wb_data, input int exp_fill,
                              input logic [31:0] exp_fill_addr);
    vec_t v;
    v.name = name; v.we = we; v.byt = byt; v.addr = addr; v.wdata = wdata; v.lat = lat;
    v.chk_rd = chk_rd; v.exp_rdata = exp_rdata; v.exp_stalls = exp_stalls;
    v.exp_wb = exp_wb; v.exp_wb_addr = exp_wb_addr; v.exp_wb_data = exp_wb_data;
    v.exp_fill = exp_fill; v.exp_fill_addr = exp_fill_addr;
    return v;
  endfunction

  // Called at a falling edge; holds the request until it hits, answering
  // memory requests after 'lat' cycles of mem_req_valid.
  task automatic access(input logic we, input logic byt, input logic [31:0] addr,
                        input logic [31:0] wdata, input int lat);
    int req_cycles;
    logic [31:0] a;
    obs_stalls = 0; obs_wb = 0; obs_fill = 0; obs_rdata = 32'd0;
    obs_wb_addr = 32'd0; obs_fill_addr = 32'd0; obs_wb_data = '0;
    obs_done = 1'b0; obs_leak = 1'b0; req_cycles = 0;
    bus_if.req_valid = 1'b1; bus_if.req_we = we; bus_if.req_byte = byt;
    bus_if.req_addr = addr; bus_if.req_wdata = wdata;
    for (int c = 0; c < 200 && !obs_done; c++) begin
      #1;
      if (bus_if.rsp_hit) begin
        obs_done = 1'b1;
        obs_rdata = bus_if.rsp_rdata;
      end else begin
        if (!bus_if.stall_out || bus_if.rsp_rdata != 32'd0) obs_leak = 1'b1;
        obs_stalls++;
        if (bus_if.mem_req_valid) begin
          req_cycles++;
          a = bus_if.mem_req_addr;
          if (bus_if.mem_req_we) begin
            if (req_cycles == 1) obs_wb++;
            obs_wb_addr = a;
            obs_wb_data = bus_if.mem_req_wdata;
          end else begin
            if (req_cycles == 1) obs_fill++;
            obs_fill_addr = a;
          end
          if (req_cycles >= lat) begin
            bus_if.mem_rsp_valid = 1'b1;
            if (bus_if.mem_req_we) begin
              mem_img[a] = bus_if.mem_req_wdata;
              bus_if.mem_rsp_rdata = '0;
            end else begin
              bus_if.mem_rsp_rdata = mem_img.exists(a) ? mem_img[a] : 128'd0;
            end
            req_cycles = 0;
          end else begin
            bus_if.mem_rsp_valid = 1'b0;
          end
        end else begin
          bus_if.mem_rsp_valid = 1'b0;
          req_cycles = 0;
        end
        @(negedge clk);
      end
    end
    bus_if.mem_rsp_valid = 1'b0;
    @(negedge clk);
    bus_if.req_valid = 1'b0; bus_if.req_we = 1'b0; bus_if.req_byte = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    access(v.we, v.byt, v.addr, v.wdata, v.lat);
    check32({v.name, " hit_reached"}, 32'(obs_done), 32'd1);
    check32({v.name, " stall_cycles"}, 32'(obs_stalls), 32'(v.exp_stalls));
    check32({v.name, " stall_rdata_clean"}, 32'(obs_leak), 32'd0);
    check32({v.name, " writebacks"}, 32'(obs_wb), 32'(v.exp_wb));
    check32({v.name, " fills"}, 32'(obs_fill), 32'(v.exp_fill));
    if (v.chk_rd) check32({v.name, " rdata"}, obs_rdata, v.exp_rdata);
    if (v.exp_wb != 0) begin
      check32({v.name, " wb_addr"}, obs_wb_addr, v.exp_wb_addr);
      check128({v.name, " wb_data"}, obs_wb_data, v.exp_wb_data);
    end
    if (v.exp_fill != 0) check32({v.name, " fill_addr"}, obs_fill_addr, v.exp_fill_addr);
  endtask

  task automatic check_idle_outputs(input string tag);
    check32({tag, " rsp_hit"}, 32'(bus_if.rsp_hit), 32'd0);
    check32({tag, " rsp_rdata"}, bus_if.rsp_rdata, 32'd0);
    check32({tag, " stall_out"}, 32'(bus_if.stall_out), 32'd0);
    check32({tag, " mem_req_valid"}, 32'(bus_if.mem_req_valid), 32'd0);
    check32({tag, " mem_req_we"}, 32'(bus_if.mem_req_we), 32'd0);
    check32({tag, " mem_req_addr"}, bus_if.mem_req_addr, 32'd0);
    check128({tag, " mem_req_wdata"}, bus_if.mem_req_wdata, 128'd0);
  endtask

  initial begin
    bit seen;
    logic [127:0] z = '0;
    logic [127:0] merged = 128'h33333333_12345678_11111111_DEADA5EF;

    mem_img[32'h100] = 128'h33333333_22222222_11111111_DEADBEEF;
    mem_img[32'h140] = 128'hCAFE0003_CAFE0002_CAFE0001_CAFE0000;
    mem_img[32'h200] = 128'hA0000003_A0000002_A0000001_A0000000;
    mem_img[32'h210] = 128'hB0000003_B0000002_B0000001_B0000000;
    mem_img[32'h300] = 128'h0;

    //               name            we    byt   addr        wdata         lat chk  exp_rdata      stl wb wb_addr  wb_data  fill fill_addr
    vecs[0]  = mk("cold_ld_100",   1'b0, 1'b0, 32'h100, 32'h0,         5, 1, 32'hDEADBEEF, 7, 0, 32'h0,   z,      1, 32'h100);
    vecs[1]  = mk("st_byte_101",   1'b1, 1'b1, 32'h101, 32'hFFFFFFA5,  1, 0, 32'h0,        0, 0, 32'h0,   z,      0, 32'h0);
    vecs[2]  = mk("ld_word_100",   1'b0, 1'b0, 32'h100, 32'h0,         1, 1, 32'hDEADA5EF, 0, 0, 32'h0,   z,      0, 32'h0);
    vecs[3]  = mk("ld_byte_101",   1'b0, 1'b1, 32'h101, 32'h0,         1, 1, 32'h000000A5, 0, 0, 32'h0,   z,      0, 32'h0);
    vecs[4]  = mk("ld_word_10e",   1'b0, 1'b0, 32'h10E, 32'h0,         1, 1, 32'h33333333, 0, 0, 32'h0,   z,      0, 32'h0);
    vecs[5]  = mk("st_word_10a",   1'b1, 1'b0, 32'h10A, 32'h12345678,  1, 0, 32'h0,        0, 0, 32'h0,   z,      0, 32'h0);
    vecs[6]  = mk("ld_140_dirty",  1'b0, 1'b0, 32'h140, 32'h0,         2, 1, 32'hCAFE0000, 6, 1, 32'h100, merged, 1, 32'h140);
    vecs[7]  = mk("ld_100_refill", 1'b0, 1'b0, 32'h100, 32'h0,         1, 1, 32'hDEADA5EF, 3, 0, 32'h0,   z,      1, 32'h100);
    vecs[8]  = mk("ld_108",        1'b0, 1'b0, 32'h108, 32'h0,         1, 1, 32'h12345678, 0, 0, 32'h0,   z,      0, 32'h0);
    vecs[9]  = mk("st_miss_214",   1'b1, 1'b0, 32'h214, 32'hFEEDF00D,  1, 0, 32'h0,        3, 0, 32'h0,   z,      1, 32'h210);
    vecs[10] = mk("ld_210",        1'b0, 1'b0, 32'h210, 32'h0,         1, 1, 32'hB0000000, 0, 0, 32'h0,   z,      0, 32'h0);
    vecs[11] = mk("ld_214",        1'b0, 1'b0, 32'h214, 32'h0,         1, 1, 32'hFEEDF00D, 0, 0, 32'h0,   z,      0, 32'h0);
    vecs[12] = mk("ld_200_miss",   1'b0, 1'b0, 32'h200, 32'h0,         1, 1, 32'hA0000000, 3, 0, 32'h0,   z,      1, 32'h200);
    vecs[13] = mk("ld_218_hit",    1'b0, 1'b0, 32'h218, 32'h0,         1, 1, 32'hB0000002, 0, 0, 32'h0,   z,      0, 32'h0);
    vecs[14] = mk("ld_204_hit",    1'b0, 1'b0, 32'h204, 32'h0,         1, 1, 32'hA0000001, 0, 0, 32'h0,   z,      0, 32'h0);
    vecs[15] = mk("post_rst_100",  1'b0, 1'b0, 32'h100, 32'h0,         1, 1, 32'hDEADA5EF, 3, 0, 32'h0,   z,      1, 32'h100);
    vecs[16] = mk("post_rst_214",  1'b0, 1'b0, 32'h214, 32'h0,         1, 1, 32'hB0000001, 3, 0, 32'h0,   z,      1, 32'h210);
    vecs[17] = mk("ld_byte_103",   1'b0, 1'b1, 32'h103, 32'h0,         1, 1, 32'h000000DE, 0, 0, 32'h0,   z,      0, 32'h0);

    rst = 1'b1;
    bus_if.req_valid = 1'b0; bus_if.req_we = 1'b0; bus_if.req_byte = 1'b0;
    bus_if.req_addr = 32'd0; bus_if.req_wdata = 32'd0;
    bus_if.mem_rsp_valid = 1'b0; bus_if.mem_rsp_rdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_idle_outputs("reset");
    @(negedge clk);

    for (int i = 0; i < 15; i++) run_vec(vecs[i]);

    // Reset while a fill is outstanding, then a late memory response
    bus_if.req_valid = 1'b1; bus_if.req_we = 1'b0; bus_if.req_byte = 1'b0;
    bus_if.req_addr = 32'h300;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      #1;
      if (bus_if.mem_req_valid) seen = 1'b1;
      @(negedge clk);
    end
    check32("midfill fill_seen", 32'(seen), 32'd1);
    rst = 1'b1;
    bus_if.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_idle_outputs("midfill_reset");
    @(negedge clk);
    bus_if.mem_rsp_valid = 1'b1;
    bus_if.mem_rsp_rdata = {4{32'h5A5A5A5A}};
    @(negedge clk);
    bus_if.mem_rsp_valid = 1'b0;
    bus_if.mem_rsp_rdata = '0;
    #1;
    check_idle_outputs("late_rsp");
    @(negedge clk);

    for (int i = 15; i < 18; i++) run_vec(vecs[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
